// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, single-outstanding imem requester, and a small instruction FIFO toward decode.
// Latency: first instr_valid 2 cycles after reset release with zero-wait memory; sustained rate 1 instr / 2 cycles.
// Backpressure: instr_ready low fills the FIFO, and then imem_req drops until a slot frees; redirect flushes the FIFO and any in-flight word.
//
// Ports:
//   clk, rst                      clock (rising edge) and asynchronous active-high reset
//   imem_req/imem_addr/imem_ready request side of the instruction-memory port (ready/valid)
//   imem_rvalid/imem_rdata        response side; one response per accepted request, at least 1 cycle later
//   redirect_valid/redirect_pc    taken branch/jump from execute; restarts fetch at redirect_pc (word aligned)
//   instr_valid/instr/instr_pc    FIFO head toward decode; NOP and pc 0 when empty
//   instr_ready                   decode consumes the head when instr_valid & instr_ready
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int          AW      = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(BUF_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_ent_t;

    state_t        state_q;
    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    fetch_ent_t    fifo_mem [BUF_DEPTH];
    fetch_ent_t    head_ent;
    fetch_ent_t    push_ent;

    logic not_full;
    logic req_fire;
    logic push;
    logic pop;

    // Requests are only issued when a FIFO slot is guaranteed for the response,
    // so a push can never find the FIFO full. A redirect cycle never issues:
    // the address on the bus would be stale by the time it is accepted.
    assign not_full  = (count_q < DEPTH_C);
    assign imem_req  = ~rst & (state_q == S_REQ) & not_full & ~redirect_valid;
    assign imem_addr = pc_q;
    assign req_fire  = imem_req & imem_ready;

    // Redirect squashes both the returning word and the consumer handshake:
    // everything in the FIFO belongs to the wrong path.
    assign push = (state_q == S_WAIT) & imem_rvalid & ~redirect_valid;
    assign pop  = instr_valid & instr_ready & ~redirect_valid;

    assign push_ent.pc   = req_pc_q;
    assign push_ent.word = imem_rdata;

    assign head_ent    = fifo_mem[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? head_ent.word : NOP;
    assign instr_pc    = instr_valid ? head_ent.pc : 32'h0;

    // Fetch control: PC, in-flight request PC and request/response tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[31:2], 2'b00};
            case (state_q)
                // A request is still in flight; its response must be swallowed.
                S_WAIT:  state_q <= imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_q <= imem_rvalid ? S_REQ : S_DROP;
                default: state_q <= S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties it in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_ent;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] K        = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Samples of the cycle that just ended (taken at the falling edge).
    logic        s_req, s_acc, s_vld, s_rv;
    logic [31:0] s_addr, s_instr, s_pc;

    // Memory responder knobs.
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 never ready
    int          lat = 1;
    bit          lat_rand = 0;
    bit          inj_rvalid = 0;
    int          pend_left = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pops = 0;

    // Reference model: fetch order as a queue of expected PCs.
    logic [31:0] exp_out[$];
    int          m_buf = 0;
    logic [31:0] m_pc = RESET_PC;
    bit          m_out = 0;
    bit          m_stale = 0;

    task automatic respond();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend_left > 0) begin
            pend_left--;
            if (pend_left == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr ^ K;
            end
        end
        if (inj_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        case (ready_mode)
            0:       imem_ready = 1'b1;
            1:       imem_ready = ($urandom_range(0, 3) != 0);
            default: imem_ready = 1'b0;
        endcase
    endtask

    task automatic model_step();
        bit          rd;
        bit          pop;
        logic        exp_vld;
        logic [31:0] f;
        rd      = redirect_valid;
        pop     = s_vld & instr_ready & ~rd;
        exp_vld = (m_buf > 0);
        checks++;
        if (s_vld !== exp_vld) begin errors++; $display("FAIL model_valid t=%0t got %b exp %b", $time, s_vld, exp_vld); end
        if (!s_vld) begin
            checks++;
            if (s_instr !== NOP || s_pc !== 32'h0) begin errors++; $display("FAIL model_empty_out t=%0t got %h/%h exp %h/0", $time, s_instr, s_pc, NOP); end
        end
        if (m_buf >= DEPTH || rd) begin
            checks++;
            if (s_req !== 1'b0) begin errors++; $display("FAIL model_req_gate t=%0t got %b exp 0 (buf=%0d rd=%b)", $time, s_req, m_buf, rd); end
        end
        if (s_acc) begin
            checks++;
            if (m_out) begin errors++; $display("FAIL model_outstanding t=%0t got 2 exp 1", $time); end
            checks++;
            if (s_addr !== m_pc) begin errors++; $display("FAIL model_addr t=%0t got %h exp %h", $time, s_addr, m_pc); end
        end
        if (s_rv && m_out) begin
            m_out = 0;
            if (!m_stale && !rd) m_buf++;
        end
        if (pop) begin
            pops++;
            checks++;
            if (exp_out.size() == 0) begin
                errors++; $display("FAIL model_pop_empty t=%0t got pc %h exp none", $time, s_pc);
            end else begin
                f = exp_out.pop_front();
                if (s_pc !== f || s_instr !== (f ^ K)) begin errors++; $display("FAIL model_pop t=%0t got %h/%h exp %h/%h", $time, s_pc, s_instr, f, f ^ K); end
            end
            m_buf--;
        end
        if (rd) begin
            exp_out.delete();
            m_buf   = 0;
            m_stale = m_out;
            m_pc    = {redirect_pc[31:2], 2'b00};
        end
        if (s_acc) begin
            exp_out.push_back(m_pc);
            m_pc    = m_pc + 32'd4;
            m_out   = 1;
            m_stale = 0;
        end
    endtask

    // One clock cycle: sample and check at the falling edge, then drive memory after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_vld   = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_rv    = imem_rvalid;
        s_acc   = imem_req & imem_ready;
        model_step();
        if (s_acc) begin
            pend_addr = s_addr;
            pend_left = lat_rand ? int'($urandom_range(1, 3)) : lat;
        end
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        pend_left      = 0;
        exp_out.delete();
        m_buf   = 0;
        m_pc    = RESET_PC;
        m_out   = 0;
        m_stale = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        respond();
    endtask

    task automatic setup(input int rm, input int l, input bit lr, input logic ir);
        ready_mode  = rm;
        lat         = l;
        lat_rand    = lr;
        instr_ready = ir;
        inj_rvalid  = 0;
    endtask

    task automatic test_reset();
        setup(0, 1, 0, 1'b1);
        imem_ready = 1'b1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", instr_valid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", instr, NOP); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", instr_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        setup(0, 1, 0, 1'b1);
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (s_req !== ((c % 2) == 0)) begin errors++; $display("FAIL t1_req c%0d got %b exp %b", c, s_req, (c % 2) == 0); end
            if ((c % 2) == 0) begin
                checks++; if (s_addr !== 32'(2 * c)) begin errors++; $display("FAIL t1_addr c%0d got %h exp %h", c, s_addr, 2 * c); end
            end
            checks++;
            if (s_vld !== (c >= 2 && (c % 2) == 0)) begin errors++; $display("FAIL t1_vld c%0d got %b", c, s_vld); end
            if (c >= 2 && (c % 2) == 0) begin
                p = 32'(2 * (c - 2));
                checks++;
                if (s_pc !== p || s_instr !== (p ^ K)) begin errors++; $display("FAIL t1_head c%0d got %h/%h exp %h/%h", c, s_pc, s_instr, p, p ^ K); end
            end
        end
    endtask

    task automatic test_backpressure();
        setup(0, 1, 0, 1'b0);
        do_reset();
        for (int c = 0; c < 11; c++) begin
            instr_ready = (c >= 8);
            tick();
            if (c == 5) begin
                checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL t2_full_req got %b exp 0", s_req); end
                checks++; if (s_vld !== 1'b1 || s_pc !== 32'h0) begin errors++; $display("FAIL t2_hold got %b/%h exp 1/0", s_vld, s_pc); end
            end
            if (c == 8) begin
                checks++; if (s_vld !== 1'b1 || s_pc !== 32'h0) begin errors++; $display("FAIL t2_pop0 got %b/%h exp 1/0", s_vld, s_pc); end
            end
            if (c == 9) begin
                checks++; if (s_vld !== 1'b1 || s_pc !== 32'h4) begin errors++; $display("FAIL t2_pop4 got %b/%h exp 1/4", s_vld, s_pc); end
                checks++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin errors++; $display("FAIL t2_next got %b/%h exp 1/8", s_req, s_addr); end
            end
            if (c == 10) begin
                checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL t2_drained got %b exp 0", s_vld); end
            end
        end
    endtask

    task automatic test_mem_stall();
        setup(2, 1, 0, 1'b1);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL t3_stall c%0d got %b/%h exp 1/%h", c, s_req, s_addr, RESET_PC); end
        end
        ready_mode = 0;
        imem_ready = 1'b1;
        tick();
        checks++; if (s_acc !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL t3_accept got %b/%h exp 1/%h", s_acc, s_addr, RESET_PC); end
        tick();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL t3_wait_req got %b exp 0", s_req); end
        tick();
        checks++; if (s_vld !== 1'b1 || s_pc !== RESET_PC) begin errors++; $display("FAIL t3_out got %b/%h exp 1/%h", s_vld, s_pc, RESET_PC); end
    endtask

    task automatic test_redirect_wait();
        setup(0, 3, 0, 1'b1);
        do_reset();
        tick();
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL t4_redir_req got %b exp 0", s_req); end
        for (int c = 2; c < 7; c++) begin
            tick();
            if (c <= 3) begin
                checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL t4_drop_req c%0d got %b exp 0", c, s_req); end
            end
            if (c == 3) begin
                checks++; if (s_rv !== 1'b1) begin errors++; $display("FAIL t4_rvalid got %b exp 1", s_rv); end
            end
            if (c == 4) begin
                checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL t4_newaddr got %b/%h exp 1/100", s_req, s_addr); end
            end
            if (c <= 5) begin
                checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL t4_novld c%0d got %b exp 0", c, s_vld); end
            end
            if (c == 6) begin
                checks++;
                if (s_vld !== 1'b1 || s_pc !== 32'h100 || s_instr !== (32'h100 ^ K)) begin errors++; $display("FAIL t4_first got %b/%h/%h exp 1/100/%h", s_vld, s_pc, s_instr, 32'h100 ^ K); end
            end
        end
    endtask

    task automatic test_redirect_rvalid();
        setup(0, 1, 0, 1'b0);
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        checks++; if (s_vld !== 1'b1 || s_rv !== 1'b1) begin errors++; $display("FAIL t5_setup got vld %b rv %b exp 1/1", s_vld, s_rv); end
        tick();
        checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL t5_flush got %b exp 0", s_vld); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL t5_addr got %b/%h exp 1/100", s_req, s_addr); end
        repeat (2) tick();
        checks++; if (s_vld !== 1'b1 || s_pc !== 32'h100) begin errors++; $display("FAIL t5_first got %b/%h exp 1/100", s_vld, s_pc); end
    endtask

    task automatic test_reset_mid_wait();
        setup(0, 1, 0, 1'b0);
        do_reset();
        repeat (2) tick();
        lat = 3;
        tick();
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL t6_pre got %b exp 1", instr_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
            errors++; $display("FAIL t6_async got %b/%b/%h/%h exp 0/0/%h/0", imem_req, instr_valid, instr, instr_pc, NOP);
        end
        setup(2, 1, 0, 1'b1);
        inj_rvalid = 1;
        do_reset();
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL t6_addr got %b/%h exp 1/%h", s_req, s_addr, RESET_PC); end
        tick();
        inj_rvalid = 0;
        ready_mode = 0;
        imem_ready = 1'b1;
        tick();
        checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL t6_stale got %b exp 0", s_vld); end
        repeat (2) tick();
        checks++; if (s_vld !== 1'b1 || s_pc !== RESET_PC || s_instr !== (RESET_PC ^ K)) begin errors++; $display("FAIL t6_first got %b/%h/%h", s_vld, s_pc, s_instr); end
    endtask

    task automatic test_random();
        setup(1, 1, 1, 1'b1);
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if (redirect_valid) begin
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                else                           redirect_pc = $urandom_range(0, 4095);
            end
            tick();
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        ready_mode     = 0;
        lat_rand       = 0;
        lat            = 1;
        repeat (5) tick();
        pops = 0;
        repeat (40) tick();
        checks++; if (pops < 15) begin errors++; $display("FAIL rand_throughput got %0d pops exp >= 15", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_mem_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
